// File: rtl/instr_encoder.sv
// Encodes a field bundle into a 32-bit instruction word. Words queue in a small
// FIFO that drains to instruction memory at sequentially increasing addresses.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_nop,
    input  logic [1:0]               in_fmt_2,
    input  logic [5:0]               in_op_type_6,
    input  logic [4:0]               in_rs_addr_5,
    input  logic [4:0]               in_rt_addr_5,
    input  logic [4:0]               in_rd_addr_5,
    input  logic [4:0]               in_sh_amt_5,
    input  logic [15:0]              in_imm_val_16,
    input  logic [25:0]              in_imm_val_26,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr_32,
    output logic [31:0]              out_addr_32,
    output logic [$clog2(DEPTH):0]   out_count,
    output logic                     err_sticky
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] FMT_R      = 2'd0;
    localparam logic [1:0] FMT_I      = 2'd1;
    localparam logic [1:0] FMT_J      = 2'd2;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic          err_q, err_d;
    logic          armed_q;

    logic [31:0]   word_d;
    logic          illegal;
    logic          accept;
    logic          push;
    logic          pop;

    always_comb begin
        word_d = '0;
        unique case (in_fmt_2)
            FMT_R:   word_d = {6'b000000, in_rs_addr_5, in_rt_addr_5, in_rd_addr_5,
                               in_sh_amt_5, in_op_type_6};
            FMT_I:   word_d = {in_op_type_6, in_rs_addr_5, in_rt_addr_5, in_imm_val_16};
            FMT_J:   word_d = {in_op_type_6, in_imm_val_26};
            default: word_d = {6'b000001, in_rs_addr_5, in_op_type_6[5:1], in_imm_val_16};
        endcase
        if (in_nop) begin
            word_d = '0;
        end
    end

    // REGIMM carries rt<<1, so an odd op is malformed; I/J opcodes 0 and 1
    // collide with the SPECIAL and REGIMM major opcodes.
    assign illegal = !in_nop &&
                     (((in_fmt_2 == 2'd3) && in_op_type_6[0]) ||
                      (((in_fmt_2 == FMT_I) || (in_fmt_2 == FMT_J)) &&
                       (in_op_type_6[5:1] == 5'd0)));

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; ready never looks at the consumer side in the same cycle.
    assign in_ready  = armed_q && !clear && (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);

    assign accept = in_valid && in_ready;
    assign push   = accept && !illegal;
    assign pop    = out_valid && out_ready && !clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        err_d    = err_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            addr_d   = BASE_ADDR;
            err_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                addr_d   = addr_q + 32'd4;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (accept && illegal) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE_ADDR;
            err_q    <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
            armed_q  <= 1'b1;
        end
    end

    // Storage needs no reset: a slot is only visible once the count covers it.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word_d;
        end
    end

    assign out_instr_32 = out_valid ? mem_q[rd_ptr_q] : 32'h0000_0000;
    assign out_addr_32  = addr_q;
    assign out_count    = count_q;
    assign err_sticky   = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a queue-based model checked every cycle, plus
// hand-computed words and addresses for the directed scenarios.
module tb_instr_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'hFFFF_FFF8;

    typedef struct packed {
        logic        nop;
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [15:0] i16;
        logic [25:0] i26;
    } bundle_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    bundle_t     drv = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr_32;
    logic [31:0] out_addr_32;
    logic [2:0]  out_count;
    logic        err_sticky;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    logic [31:0] exp_q[$];
    logic [31:0] m_addr = BASE;
    logic        m_err = 1'b0;
    logic        m_armed = 1'b0;

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .clear         (clear),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_nop        (drv.nop),
        .in_fmt_2      (drv.fmt),
        .in_op_type_6  (drv.op),
        .in_rs_addr_5  (drv.rs),
        .in_rt_addr_5  (drv.rt),
        .in_rd_addr_5  (drv.rd),
        .in_sh_amt_5   (drv.sh),
        .in_imm_val_16 (drv.i16),
        .in_imm_val_26 (drv.i26),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr_32  (out_instr_32),
        .out_addr_32   (out_addr_32),
        .out_count     (out_count),
        .err_sticky    (err_sticky)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- model ----------------
    function automatic logic [31:0] model_word(input bundle_t b);
        if (b.nop) return 32'd0;
        case (b.fmt)
            2'd0:    return (32'(b.rs) << 21) | (32'(b.rt) << 16) | (32'(b.rd) << 11) |
                            (32'(b.sh) << 6) | 32'(b.op);
            2'd1:    return (32'(b.op) << 26) | (32'(b.rs) << 21) | (32'(b.rt) << 16) | 32'(b.i16);
            2'd2:    return (32'(b.op) << 26) | 32'(b.i26);
            default: return (32'd1 << 26) | (32'(b.rs) << 21) | (32'(b.op / 2) << 16) | 32'(b.i16);
        endcase
    endfunction

    function automatic bit model_illegal(input bundle_t b);
        if (b.nop) return 1'b0;
        if (b.fmt == 2'd3) return (b.op % 2) == 1;
        if (b.fmt == 2'd1 || b.fmt == 2'd2) return b.op < 6'd2;
        return 1'b0;
    endfunction

    always @(posedge clock or negedge reset_n) begin : model
        bit acc;
        bit pp;
        if (!reset_n) begin
            exp_q.delete();
            m_addr  <= BASE;
            m_err   <= 1'b0;
            m_armed <= 1'b0;
        end else begin
            m_armed <= 1'b1;
            if (clear) begin
                exp_q.delete();
                m_addr <= BASE;
                m_err  <= 1'b0;
            end else begin
                acc = in_valid && m_armed && (exp_q.size() < DEPTH);
                pp  = (exp_q.size() > 0) && out_ready;
                if (pp) begin
                    void'(exp_q.pop_front());
                    m_addr <= m_addr + 32'd4;
                end
                if (acc) begin
                    if (model_illegal(drv)) m_err <= 1'b1;
                    else exp_q.push_back(model_word(drv));
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            check("cmp_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("cmp_count", 32'(out_count), 32'(exp_q.size()));
            check("cmp_instr", out_instr_32, (exp_q.size() != 0) ? exp_q[0] : 32'd0);
            check("cmp_addr", out_addr_32, m_addr);
            check("cmp_err", 32'(err_sticky), 32'(m_err));
            check("cmp_ready", 32'(in_ready),
                  32'(m_armed && !clear && (exp_q.size() < DEPTH)));
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bundle_t b);
        drv      = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    function automatic bundle_t mk(input logic nop, input logic [1:0] fmt, input logic [5:0] op,
                                   input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                   input logic [4:0] sh, input logic [15:0] i16,
                                   input logic [25:0] i26);
        bundle_t b;
        b = '{nop: nop, fmt: fmt, op: op, rs: rs, rt: rt, rd: rd, sh: sh, i16: i16, i26: i26};
        return b;
    endfunction

    bundle_t     tbl [5];
    logic [31:0] tbl_word [4];

    initial begin
        tbl[0] = mk(0, 2'd0, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        tbl[1] = mk(0, 2'd1, 6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
        tbl[2] = mk(0, 2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h010_0000);
        tbl[3] = mk(0, 2'd3, 6'h22, 5'd4, 5'd0, 5'd0, 5'd0, 16'hFFFE, 26'h0);
        tbl[4] = mk(0, 2'd0, 6'h08, 5'd31, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        tbl_word[0] = 32'h0022_1820;
        tbl_word[1] = 32'h8FA8_0004;
        tbl_word[2] = 32'h0C10_0000;
        tbl_word[3] = 32'h0491_FFFE;

        // reset state, forced without a clock edge
        #1 reset_n = 1'b0;
        #1;
        check_en = 1'b1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_instr", out_instr_32, 32'd0);
        check("rst_addr", out_addr_32, BASE);
        check("rst_err", 32'(err_sticky), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        step();
        @(negedge clock);
        #1 reset_n = 1'b1;
        #1 check("ready_before_edge", 32'(in_ready), 32'd0);
        step();
        check("ready_after_edge", 32'(in_ready), 32'd1);

        // R-type, latency one, then address steps by 4
        out_ready = 1'b1;
        drive(mk(0, 2'd0, 6'h21, 5'd3, 5'd4, 5'd5, 5'd0, 16'h0, 26'h0));
        check("r_word", out_instr_32, 32'h0064_2821);
        check("r_addr", out_addr_32, BASE);
        step();
        check("r_addr_next", out_addr_32, BASE + 32'd4);
        check("r_empty_instr", out_instr_32, 32'd0);

        // I, J, REGIMM held then drained
        out_ready = 1'b0;
        drive(mk(0, 2'd1, 6'h09, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0));
        drive(mk(0, 2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0040));
        drive(mk(0, 2'd3, 6'h02, 5'd7, 5'd0, 5'd0, 5'd0, 16'h0010, 26'h0));
        check("ijr_count", 32'(out_count), 32'd3);
        out_ready = 1'b1;
        check("addiu_word", out_instr_32, 32'h2422_FFFF);
        step();
        check("j_word", out_instr_32, 32'h0800_0040);
        step();
        check("regimm_word", out_instr_32, 32'h04E1_0010);
        step();
        check("ijr_drained", 32'(out_valid), 32'd0);

        // back-pressure up to full, drain across the 32-bit address wrap
        out_ready = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) drive(tbl[i]);
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_count", 32'(out_count), 32'd4);
        drive(tbl[4]);
        check("full_no_accept", 32'(out_count), 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_word", out_instr_32, tbl_word[i]);
            check("drain_addr", out_addr_32, BASE + 32'(4 * i));
            step();
        end
        check("drain_empty", 32'(out_valid), 32'd0);

        // simultaneous push and pop keeps occupancy
        out_ready = 1'b0;
        drive(tbl[0]);
        drive(tbl[1]);
        out_ready = 1'b1;
        drive(tbl[2]);
        check("pp_count", 32'(out_count), 32'd2);
        check("pp_head", out_instr_32, tbl_word[1]);
        drive(tbl[3]);
        check("pp_head2", out_instr_32, tbl_word[2]);
        step();
        step();

        // illegal bundles are consumed but not stored; NOP overrides fields
        out_ready = 1'b0;
        drive(mk(0, 2'd3, 6'h01, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0));
        check("ill_count", 32'(out_count), 32'd0);
        check("ill_err", 32'(err_sticky), 32'd1);
        drive(mk(0, 2'd1, 6'h00, 5'd1, 5'd1, 5'd0, 5'd0, 16'h1, 26'h0));
        drive(mk(0, 2'd2, 6'h01, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF));
        check("ill_count2", 32'(out_count), 32'd0);
        drive(mk(1, 2'd3, 6'h01, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FF_FFFF));
        check("nop_count", 32'(out_count), 32'd1);
        check("nop_word", out_instr_32, 32'd0);
        check("err_holds", 32'(err_sticky), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("err_cleared", 32'(err_sticky), 32'd0);

        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) drive(tbl[i]);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(out_count), 32'd0);
        @(negedge clock);
        #1 reset_n = 1'b1;
        step();

        // clear with a concurrent push and pop
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive(tbl[i]);
        out_ready = 1'b1;
        clear = 1'b1;
        drv = tbl[3];
        in_valid = 1'b1;
        #1 check("clr_ready", 32'(in_ready), 32'd0);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        check("clr_count", 32'(out_count), 32'd0);
        check("clr_addr", out_addr_32, BASE);

        // mixed stream with irregular back-pressure
        for (int i = 0; i < 12; i++) begin
            out_ready = ((i % 3) != 0);
            drive(tbl[i % 5]);
        end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step();
        check("final_empty", 32'(out_valid), 32'd0);

        @(negedge clock);
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 4, output FIFO entries (power of two, 2..16).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, first instruction-memory write address.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 clear  input  1  synchronous flush of FIFO, address, error flag.
REQ-006 in_valid  input  1  field bundle present.
REQ-007 in_ready  output  1  encoder can accept bundle this cycle.
REQ-008 in_nop  input  1  emit NOP word; overrides all other fields.
REQ-009 in_fmt_2  input  2  0=R (SPECIAL), 1=I, 2=J, 3=REGIMM.
REQ-010 in_op_type_6  input  6  funct (R), opcode (I/J), rt<<1 (REGIMM).
REQ-011 in_rs_addr_5, in_rt_addr_5, in_rd_addr_5, in_sh_amt_5  input  5 each  register fields / shift amount.
REQ-012 in_imm_val_16  input  16  I/REGIMM immediate.
REQ-013 in_imm_val_26  input  26  J target.
REQ-014 out_valid  output  1  FIFO head holds word.
REQ-015 out_ready  input  1  instruction memory accepts word.
REQ-016 out_instr_32  output  32  encoded word at FIFO head.
REQ-017 out_addr_32  output  32  write address for head word.
REQ-018 out_count  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-019 err_sticky  output  1  illegal bundle seen since reset/clear.

Function
REQ-020 Accept occurs on cycle with in_valid=1 and in_ready=1; in_ready SHALL equal (out_count<DEPTH) and not depend on out_ready in same cycle.
REQ-021 Encoding: in_nop -> 32'h0000_0000; R -> {6'b000000, rs, rt, rd, sh_amt, op_type}; I -> {op_type, rs, rt, imm16}; J -> {op_type, imm26}; REGIMM -> {6'b000001, rs, op_type[5:1], imm16}.
REQ-022 Illegal bundle: in_nop=0 and (fmt=3 with op_type[0]=1, or fmt=1/2 with op_type=000000 or 000001); accepted (consumes handshake), not written to FIFO, err_sticky set next edge.
REQ-023 Legal accepted word SHALL appear at FIFO tail; if FIFO empty, out_valid=1 and out_instr_32 valid on cycle after accept (latency 1); no combinational in->out path.
REQ-024 Pop occurs on cycle with out_valid=1 and out_ready=1; out_addr_32 SHALL increment by 4 on each pop, wrapping modulo 2^32.
REQ-025 Simultaneous legal push and pop: occupancy unchanged, order preserved.
REQ-026 Full (out_count=DEPTH): in_ready=0 even if out_ready=1; ready returns the cycle after a pop.
REQ-027 Empty: out_valid=0; out_instr_32 SHALL hold 0; out_ready ignored.
REQ-028 FIFO pointers wrap modulo DEPTH; words emitted strictly in accept order.
REQ-029 clear=1 on an edge: FIFO emptied, out_addr_32=BASE_ADDR, err_sticky=0; concurrent push and pop ignored; in_ready=0 during the clear cycle.

Reset
REQ-030 reset_n=0 SHALL immediately force out_valid=0, out_count=0, out_instr_32=0, out_addr_32=BASE_ADDR, err_sticky=0, in_ready=0.
REQ-031 in_ready SHALL rise on first rising edge after reset_n deasserts; reset mid-transfer discards all stored words, no partial output.

Verification
REQ-032 R-type: fmt=0, rs=3, rt=4, rd=5, sh=0, op=6'h21, out_ready=1 -> next cycle out_instr_32=32'h0064_2821, out_addr_32=BASE_ADDR, following pop addr +4.
REQ-033 I/J/REGIMM: ADDIU op=6'h09 rs=1 rt=2 imm=16'hFFFF -> 32'h2422_FFFF; J op=6'h02 imm26=26'h000_0040 -> 32'h0800_0040; REGIMM op=6'h02 rs=7 imm=16'h0010 -> 32'h04E1_0010.
REQ-034 Full/back-pressure: out_ready=0, push 5 bundles with DEPTH=4 -> in_ready=0 after 4th, out_count=4; raise out_ready -> words drain in order, addresses BASE, +4, +8, +12.
REQ-035 Illegal: fmt=3 op=6'h01 -> accepted, out_count unchanged, err_sticky=1 until clear; in_nop=1 with any fields -> 32'h0000_0000.
REQ-036 Reset/clear mid-stream: 3 words queued, reset_n=0 asynchronously -> out_valid=0, out_count=0 without clock edge; repeat with clear=1 and simultaneous push -> empty FIFO, address BASE_ADDR.
